rsv_issue_scheduler: RTL and testbench

Picks one reservation-station entry per cycle whose operands and function unit are both free, and registers it into an issue slot. Selection is round-robin among eligible entries. The block sits between the reservation station and the operand-read / function-unit datapath. It replaces plain valid-only arbitration with hazard-aware scheduling: a per-register pending scoreboard plus per-FU-type ready gating.

---
 rtl/rsv_issue_scheduler_pkg.sv | 16 +
 rtl/rsv_issue_scheduler_rr_pick.sv | 35 +++
 rtl/rsv_issue_scheduler.sv | 89 ++++++++
 tb/tb_rsv_issue_scheduler.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rsv_issue_scheduler_pkg.sv
// Shared sizing constants and index types for the reservation-station issue path.
package gDefine;

  localparam int RSV_CAPACITY = 8;
  localparam int NUM_FU_TYPES = 4;
  localparam int NUM_VREGS    = 32;

  localparam int RID_W  = $clog2(RSV_CAPACITY);
  localparam int FU_W   = $clog2(NUM_FU_TYPES);
  localparam int VREG_W = $clog2(NUM_VREGS);

  typedef logic [RID_W-1:0]  RsvID_t;
  typedef logic [VREG_W-1:0] VRegIdx_t;
  typedef logic [FU_W-1:0]   FuncUnitType_t;

endpackage

// File: rtl/rsv_issue_scheduler_rr_pick.sv
// Combinational round-robin first-one finder: lowest set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grantOh,
  output logic [IW-1:0] grantIdx,
  output logic          none
);

  logic [2*N-1:0] masked;
  logic           found;

  // The upper copy covers the wrap-around, so one priority scan sees ptr..N-1 then 0..ptr-1.
  always_comb begin
    masked   = '0;
    found    = 1'b0;
    grantIdx = '0;
    grantOh  = '0;
    for (int j = 0; j < 2*N; j++) begin
      masked[j] = req[j % N] && ((j >= N) || (j >= int'(ptr)));
    end
    for (int j = 0; j < 2*N; j++) begin
      if (!found && masked[j]) begin
        found    = 1'b1;
        grantIdx = IW'(j % N);
      end
    end
    if (found) grantOh[grantIdx] = 1'b1;
    none = !found;
  end

endmodule

// File: rtl/rsv_issue_scheduler.sv
// Hazard-aware issue scheduler: round-robin pick of an eligible reservation-station entry
// into a single registered issue slot, with a per-register pending scoreboard.
module rsv_issue_scheduler
  import gDefine::*;
(
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 stall,
  input  logic [RSV_CAPACITY-1:0]              opValid,
  input  logic [RSV_CAPACITY-1:0][FU_W-1:0]    funcUnitType,
  input  logic [RSV_CAPACITY-1:0][2:0]         srcUsed,
  input  logic [RSV_CAPACITY-1:0][VREG_W-1:0]  ra,
  input  logic [RSV_CAPACITY-1:0][VREG_W-1:0]  rb,
  input  logic [RSV_CAPACITY-1:0][VREG_W-1:0]  rc,
  input  logic [RSV_CAPACITY-1:0]              rat,
  input  logic [RSV_CAPACITY-1:0]              rbt,
  input  logic [RSV_CAPACITY-1:0]              rct,
  input  logic [RSV_CAPACITY-1:0]              rdValid,
  input  logic [RSV_CAPACITY-1:0][VREG_W-1:0]  rd,
  input  logic [RSV_CAPACITY-1:0]              rdt,
  input  logic [NUM_FU_TYPES-1:0]              fuReady,
  input  logic                                 wbValid,
  input  logic [VREG_W-1:0]                    wbReg,
  input  logic                                 wbType,
  output logic [RSV_CAPACITY-1:0]              dispatchAck,
  output logic                                 issueValid,
  input  logic                                 issueReady,
  output logic [RID_W-1:0]                     issueRid,
  output logic [FU_W-1:0]                      issueFuType
);

  logic [1:0][NUM_VREGS-1:0] pending, pendingNext;
  logic [RSV_CAPACITY-1:0]   eligible, grantOh;
  RsvID_t                    ptr, grantIdx, ptrNext;
  logic                      none, canLoad, load;

  // Hazard checks read registered scoreboard state only; a same-cycle writeback does not bypass.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < RSV_CAPACITY; i++) begin
      eligible[i] = opValid[i] && fuReady[funcUnitType[i]]
                 && !(srcUsed[i][0] && pending[rat[i]][ra[i]])
                 && !(srcUsed[i][1] && pending[rbt[i]][rb[i]])
                 && !(srcUsed[i][2] && pending[rct[i]][rc[i]])
                 && !(rdValid[i] && pending[rdt[i]][rd[i]]);
    end
  end

  rr_pick #(.N(RSV_CAPACITY), .IW(RID_W)) uPick (
    .req      (eligible),
    .ptr      (ptr),
    .grantOh  (grantOh),
    .grantIdx (grantIdx),
    .none     (none)
  );

  assign canLoad     = !stall && (!issueValid || issueReady);
  assign load        = canLoad && !none;
  assign dispatchAck = load ? grantOh : '0;
  assign ptrNext     = (grantIdx == RID_W'(RSV_CAPACITY-1)) ? '0 : grantIdx + 1'b1;

  // Set is applied after clear so a load wins over a coincident writeback.
  always_comb begin
    pendingNext = pending;
    if (wbValid) pendingNext[wbType][wbReg] = 1'b0;
    if (load && rdValid[grantIdx]) pendingNext[rdt[grantIdx]][rd[grantIdx]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issueValid  <= 1'b0;
      issueRid    <= '0;
      issueFuType <= '0;
      ptr         <= '0;
      pending     <= '0;
    end else begin
      pending <= pendingNext;
      if (load) begin
        issueValid  <= 1'b1;
        issueRid    <= grantIdx;
        issueFuType <= funcUnitType[grantIdx];
        ptr         <= ptrNext;
      end else if (issueReady) begin
        issueValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rsv_issue_scheduler.sv
// Directed bench for rsv_issue_scheduler; expected grants queued at ack time, checked at issue.
module tb_rsv_issue_scheduler;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic [7:0]      opValid;
  logic [7:0][1:0] funcUnitType;
  logic [7:0][2:0] srcUsed;
  logic [7:0][4:0] ra, rb, rc;
  logic [7:0]      rat, rbt, rct;
  logic [7:0]      rdValid;
  logic [7:0][4:0] rd;
  logic [7:0]      rdt;
  logic [3:0]      fuReady;
  logic            wbValid;
  logic [4:0]      wbReg;
  logic            wbType;
  logic [7:0]      dispatchAck;
  logic            issueValid;
  logic            issueReady;
  logic [2:0]      issueRid;
  logic [1:0]      issueFuType;

  int passCnt = 0;
  int totalCnt = 0;
  int expQ[$];

  always #5 clk = ~clk;

  rsv_issue_scheduler dut (
    .clk(clk), .rst(rst), .stall(stall), .opValid(opValid),
    .funcUnitType(funcUnitType), .srcUsed(srcUsed),
    .ra(ra), .rb(rb), .rc(rc), .rat(rat), .rbt(rbt), .rct(rct),
    .rdValid(rdValid), .rd(rd), .rdt(rdt), .fuReady(fuReady),
    .wbValid(wbValid), .wbReg(wbReg), .wbType(wbType),
    .dispatchAck(dispatchAck), .issueValid(issueValid), .issueReady(issueReady),
    .issueRid(issueRid), .issueFuType(issueFuType)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic popCheck(input string tag);
    int e;
    if (expQ.size() == 0) begin
      chk({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = expQ.pop_front();
      chk({tag, "_valid"}, 64'(issueValid), 64'd1);
      chk({tag, "_rid"}, 64'(issueRid), 64'(e));
    end
  endtask

  task automatic clearInputs();
    stall = 0; opValid = '0; funcUnitType = '0; srcUsed = '0;
    ra = '0; rb = '0; rc = '0; rat = '0; rbt = '0; rct = '0;
    rdValid = '0; rd = '0; rdt = '0; fuReady = 4'hF;
    wbValid = 0; wbReg = '0; wbType = 0; issueReady = 1;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    doReset();
    chk("reset_valid", 64'(issueValid), 64'd0);
    chk("reset_rid", 64'(issueRid), 64'd0);
    chk("reset_futype", 64'(issueFuType), 64'd0);
    chk("reset_ack", 64'(dispatchAck), 64'd0);
    chk("reset_ptr", 64'(dut.ptr), 64'd0);
    chk("reset_pending", 64'(dut.pending), 64'd0);

    // single entry, one-cycle latency
    opValid = 8'h01;
    toNeg();
    chk("single_ack", 64'(dispatchAck), 64'h01);
    expQ.push_back(0);
    tick();
    opValid = '0;
    popCheck("single");

    // all eligible, back-to-back round robin from fresh pointer
    doReset();
    for (int i = 0; i < 8; i++) funcUnitType[i] = 2'(i);
    opValid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      toNeg();
      chk($sformatf("rr_ack%0d", k), 64'(dispatchAck), 64'(8'(1) << (k % 8)));
      expQ.push_back(k % 8);
      tick();
      popCheck($sformatf("rr%0d", k));
      chk($sformatf("rr_fu%0d", k), 64'(issueFuType), 64'((k % 8) % 4));
    end

    // RAW on vector r5
    doReset();
    rdValid[2] = 1; rd[2] = 5'd5; rdt[2] = 1;
    srcUsed[3] = 3'b001; ra[3] = 5'd5; rat[3] = 1; funcUnitType[3] = 2'd1;
    opValid = 8'h04;
    toNeg();
    chk("raw_ack2", 64'(dispatchAck), 64'h04);
    expQ.push_back(2);
    tick();
    opValid = 8'h08;
    popCheck("raw_issue2");
    chk("raw_pending_set", 64'(dut.pending[1][5]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      toNeg();
      chk($sformatf("raw_blocked%0d", k), 64'(dispatchAck), 64'h00);
      tick();
    end
    chk("raw_slot_drained", 64'(issueValid), 64'd0);
    wbValid = 1; wbReg = 5'd5; wbType = 1;
    toNeg();
    chk("raw_no_bypass", 64'(dispatchAck), 64'h00);
    tick();
    wbValid = 0;
    chk("raw_pending_clr", 64'(dut.pending[1][5]), 64'd0);
    toNeg();
    chk("raw_ack3", 64'(dispatchAck), 64'h08);
    expQ.push_back(3);
    tick();
    opValid = '0;
    popCheck("raw_issue3");

    // FU type 1 not ready
    funcUnitType[4] = 2'd1;
    opValid = 8'h10;
    fuReady = 4'b1101;
    toNeg();
    chk("fu_blocked_a", 64'(dispatchAck), 64'h00);
    tick();
    chk("fu_slot_drained", 64'(issueValid), 64'd0);
    toNeg();
    chk("fu_blocked_b", 64'(dispatchAck), 64'h00);
    tick();
    fuReady = 4'hF;
    toNeg();
    chk("fu_ack4", 64'(dispatchAck), 64'h10);
    expQ.push_back(4);
    tick();
    opValid = '0;
    popCheck("fu_issue4");
    chk("fu_futype", 64'(issueFuType), 64'd1);

    // backpressure holds slot and pointer
    issueReady = 0;
    opValid = 8'h20;
    for (int k = 0; k < 3; k++) begin
      toNeg();
      chk($sformatf("hold_ack%0d", k), 64'(dispatchAck), 64'h00);
      tick();
      chk($sformatf("hold_rid%0d", k), 64'(issueRid), 64'd4);
      chk($sformatf("hold_valid%0d", k), 64'(issueValid), 64'd1);
    end
    chk("hold_ptr", 64'(dut.ptr), 64'd5);
    issueReady = 1;
    toNeg();
    chk("hold_release_ack", 64'(dispatchAck), 64'h20);
    expQ.push_back(5);
    tick();
    opValid = '0;
    popCheck("hold_issue5");

    // stall blocks load, accepted slot empties
    stall = 1;
    rdValid[6] = 1; rd[6] = 5'd7; rdt[6] = 0;
    opValid = 8'h40;
    toNeg();
    chk("stall_ack", 64'(dispatchAck), 64'h00);
    tick();
    chk("stall_drain", 64'(issueValid), 64'd0);
    chk("stall_ptr", 64'(dut.ptr), 64'd6);

    // coincident set and clear of scalar r7: set wins
    stall = 0;
    wbValid = 1; wbReg = 5'd7; wbType = 0;
    toNeg();
    chk("setclr_ack", 64'(dispatchAck), 64'h40);
    expQ.push_back(6);
    tick();
    opValid = '0;
    wbValid = 0;
    popCheck("setclr_issue6");
    chk("setclr_pending", 64'(dut.pending[0][7]), 64'd1);

    // asynchronous reset mid-stream
    rst = 1;
    #1;
    chk("midrst_valid", 64'(issueValid), 64'd0);
    chk("midrst_pending", 64'(dut.pending), 64'd0);
    chk("midrst_ptr", 64'(dut.ptr), 64'd0);
    chk("midrst_rid", 64'(issueRid), 64'd0);
    tick();
    rst = 0;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
